// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback with memory handshake.
// Optional macro MCFSM_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP with a sticky illegal_op flag.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count,
    output logic               illegal_op
);

    typedef enum logic [STATE_W-1:0] {
        FETCH     = STATE_W'(0),
        DECODE    = STATE_W'(1),
        MEM_ADDR  = STATE_W'(2),
        MEM_READ  = STATE_W'(3),
        MEM_WB    = STATE_W'(4),
        MEM_WRITE = STATE_W'(5),
        EXECUTE   = STATE_W'(6),
        R_WB      = STATE_W'(7),
        BRANCH    = STATE_W'(8),
        JUMP      = STATE_W'(9),
        IMM_EXEC  = STATE_W'(10),
        IMM_WB    = STATE_W'(11),
        TRAP      = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

`ifdef MCFSM_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:                              state_d = MEM_ADDR;
                    OP_RTYPE:                                  state_d = EXECUTE;
                    OP_BEQ, OP_BNE:                            state_d = BRANCH;
                    OP_J:                                      state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = IMM_EXEC;
`ifdef MCFSM_ILLEGAL_TRAP_EN
                    default:                                   state_d = TRAP;
`else
                    default:                                   state_d = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_d   = FETCH;
            end
            IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
                state_d   = IMM_WB;
            end
            IMM_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
`ifdef MCFSM_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset aborts the instruction in flight: no side effects in the reset cycle.
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign retire      = (state_d == FETCH) && (state_q != FETCH);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations, a negedge monitor checks them.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'b000000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;

    logic        pc_en, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        illegal_op;

    logic        pc_en4, ir_write4, i_or_d4, mem_read4, mem_write4;
    logic        reg_dst4, mem_to_reg4, reg_write4, alu_src_a4;
    logic [1:0]  alu_src_b4, alu_op4, pc_source4;
    logic [3:0]  state4;
    logic [3:0]  instr_count4;
    logic        illegal_op4;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .instr_count(instr_count), .illegal_op(illegal_op)
    );

    multicycle_control_fsm #(.CNT_W(4), .STATE_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en4), .ir_write(ir_write4), .i_or_d(i_or_d4), .mem_read(mem_read4),
        .mem_write(mem_write4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
        .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
        .alu_op(alu_op4), .pc_source(pc_source4), .state(state4),
        .instr_count(instr_count4), .illegal_op(illegal_op4)
    );

    // {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [14:0] ctl;
    assign ctl = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    localparam logic [14:0] C_FETCH_RDY  = 15'b110100000_01_00_00;
    localparam logic [14:0] C_FETCH_WAIT = 15'b000100000_01_00_00;
    localparam logic [14:0] C_DECODE     = 15'b000000000_11_00_00;
    localparam logic [14:0] C_MEM_ADDR   = 15'b000000001_10_00_00;
    localparam logic [14:0] C_MEM_READ   = 15'b001100000_00_00_00;
    localparam logic [14:0] C_MEM_WB     = 15'b000000110_00_00_00;
    localparam logic [14:0] C_MEM_WRITE  = 15'b001010000_00_00_00;
    localparam logic [14:0] C_EXECUTE    = 15'b000000001_00_10_00;
    localparam logic [14:0] C_R_WB       = 15'b000001010_00_00_00;
    localparam logic [14:0] C_BR_TAKEN   = 15'b100000001_00_01_01;
    localparam logic [14:0] C_BR_NOT     = 15'b000000001_00_01_01;
    localparam logic [14:0] C_JUMP       = 15'b100000000_00_00_10;
    localparam logic [14:0] C_IMM_ADD    = 15'b000000001_10_00_00;
    localparam logic [14:0] C_IMM_LOGIC  = 15'b000000001_10_11_00;
    localparam logic [14:0] C_IMM_WB     = 15'b000000010_00_00_00;
    localparam logic [14:0] M_ALL        = 15'b111111111_11_11_11;
    localparam logic [14:0] M_EN         = 15'b110110010_00_00_00;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [14:0] mask;
        logic [31:0] cnt;
        logic        ill;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt = '0;
    logic        exp_ill = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "state", 32'(state), 32'(e.st));
            chk(e.name, "ctl", 32'(ctl & e.mask), 32'(e.ctl & e.mask));
            chk(e.name, "instr_count", instr_count, e.cnt);
            chk(e.name, "instr_count4", 32'(instr_count4), 32'(e.cnt[3:0]));
            chk(e.name, "illegal_op", 32'(illegal_op), 32'(e.ill));
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [14:0] c, input logic [14:0] m,
                        input string nm);
        exp_t e;
        rst = r; opcode = op; zero = z; mem_ready = rdy;
        e.st = st; e.ctl = c; e.mask = m; e.cnt = exp_cnt; e.ill = exp_ill; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input string nm);
        step(1'b0, 6'b000010, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, {nm, "_fetch"});
        step(1'b0, 6'b000010, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, {nm, "_decode"});
        step(1'b0, 6'b000010, 1'b0, 1'b1, 4'd9, C_JUMP,      M_ALL, {nm, "_jump"});
        exp_cnt++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 6'b000000, 1'b0, 1'b1, 4'd0, 15'd0, M_EN, "reset");

        // R-type, mem_ready low in EXECUTE must be ignored
        step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "r_fetch");
        step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "r_decode");
        step(1'b0, 6'b000000, 1'b0, 1'b0, 4'd6, C_EXECUTE,   M_ALL, "r_exec");
        step(1'b0, 6'b000000, 1'b0, 1'b1, 4'd7, C_R_WB,      M_ALL, "r_wb");
        exp_cnt++;

        // lw with 3 wait cycles in FETCH and MEM_READ: 11 cycles
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b100011, 1'b0, 1'b0, 4'd0, C_FETCH_WAIT, M_ALL, "lw_fetch_wait");
        step(1'b0, 6'b100011, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "lw_fetch");
        step(1'b0, 6'b100011, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "lw_decode");
        step(1'b0, 6'b100011, 1'b0, 1'b1, 4'd2, C_MEM_ADDR,  M_ALL, "lw_addr");
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b100011, 1'b0, 1'b0, 4'd3, C_MEM_READ, M_ALL, "lw_read_wait");
        step(1'b0, 6'b100011, 1'b0, 1'b1, 4'd3, C_MEM_READ,  M_ALL, "lw_read");
        step(1'b0, 6'b100011, 1'b0, 1'b1, 4'd4, C_MEM_WB,    M_ALL, "lw_wb");
        exp_cnt++;

        // sw with one MEM_WRITE wait
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "sw_fetch");
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "sw_decode");
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd2, C_MEM_ADDR,  M_ALL, "sw_addr");
        step(1'b0, 6'b101011, 1'b0, 1'b0, 4'd5, C_MEM_WRITE, M_ALL, "sw_write_wait");
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd5, C_MEM_WRITE, M_ALL, "sw_write");
        exp_cnt++;

        // branches
        step(1'b0, 6'b000100, 1'b1, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "beq_fetch");
        step(1'b0, 6'b000100, 1'b1, 1'b1, 4'd1, C_DECODE,    M_ALL, "beq_decode");
        step(1'b0, 6'b000100, 1'b1, 1'b1, 4'd8, C_BR_TAKEN,  M_ALL, "beq_z1");
        exp_cnt++;
        step(1'b0, 6'b000101, 1'b1, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "bne_fetch");
        step(1'b0, 6'b000101, 1'b1, 1'b1, 4'd1, C_DECODE,    M_ALL, "bne_decode");
        step(1'b0, 6'b000101, 1'b1, 1'b1, 4'd8, C_BR_NOT,    M_ALL, "bne_z1");
        exp_cnt++;
        step(1'b0, 6'b000101, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "bne0_fetch");
        step(1'b0, 6'b000101, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "bne0_decode");
        step(1'b0, 6'b000101, 1'b0, 1'b1, 4'd8, C_BR_TAKEN,  M_ALL, "bne_z0");
        exp_cnt++;

        // I-types: addi then ori
        step(1'b0, 6'b001000, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY, M_ALL, "addi_fetch");
        step(1'b0, 6'b001000, 1'b0, 1'b1, 4'd1,  C_DECODE,    M_ALL, "addi_decode");
        step(1'b0, 6'b001000, 1'b0, 1'b1, 4'd10, C_IMM_ADD,   M_ALL, "addi_exec");
        step(1'b0, 6'b001000, 1'b0, 1'b1, 4'd11, C_IMM_WB,    M_ALL, "addi_wb");
        exp_cnt++;
        step(1'b0, 6'b001101, 1'b0, 1'b1, 4'd0,  C_FETCH_RDY, M_ALL, "ori_fetch");
        step(1'b0, 6'b001101, 1'b0, 1'b1, 4'd1,  C_DECODE,    M_ALL, "ori_decode");
        step(1'b0, 6'b001101, 1'b0, 1'b1, 4'd10, C_IMM_LOGIC, M_ALL, "ori_exec");
        step(1'b0, 6'b001101, 1'b0, 1'b1, 4'd11, C_IMM_WB,    M_ALL, "ori_wb");
        exp_cnt++;

        // illegal opcode
        step(1'b0, 6'b111111, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "ill_fetch");
        step(1'b0, 6'b111111, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "ill_decode");
`ifdef MCFSM_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++)
            step(1'b0, 6'b111111, 1'b0, 1'b1, 4'd12, 15'd0, M_ALL, "trap_hold");
        step(1'b1, 6'b111111, 1'b0, 1'b1, 4'd12, 15'd0, M_EN, "trap_reset");
        exp_ill = 1'b0;
        exp_cnt = '0;
`else
        exp_cnt++;
`endif

        // reset during MEM_WRITE wait
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd0, C_FETCH_RDY, M_ALL, "swr_fetch");
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd1, C_DECODE,    M_ALL, "swr_decode");
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd2, C_MEM_ADDR,  M_ALL, "swr_addr");
        step(1'b0, 6'b101011, 1'b0, 1'b0, 4'd5, C_MEM_WRITE, M_ALL, "swr_wait");
        step(1'b1, 6'b101011, 1'b0, 1'b0, 4'd5, 15'd0,       M_EN,  "swr_reset");
        exp_cnt = '0;

        // 17 jumps: 4-bit counter wraps 15 -> 0 -> 1
        for (int i = 0; i < 17; i++)
            do_jump($sformatf("j%0d", i));
        step(1'b0, 6'b000000, 1'b0, 1'b0, 4'd0, C_FETCH_WAIT, M_ALL, "j_final");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
